reg_bank_ops: RTL

- Parametrised successor to the processor's single 8-bit data register.
- Holds NUM_REGS general registers of WIDTH bits with one-cycle ops: load, clear, increment, decrement, move and atomic swap.
- Two combinational read ports feed the datapath buses.
- Serves the image down-sampling core as accumulator, pixel-address and counter storage.

---
 rtl/reg_bank_ops_if.sv | 41 ++++
 rtl/reg_bank_ops.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/reg_bank_ops_if.sv
// reg_bank_ops_if
//   Op-request and read-port bundle for reg_bank_ops.
//   master : the datapath controller that issues ops and reads registers.
//   slave  : the register bank itself.
//
//   op_valid, op, dst_sel, src_sel, wdata, clr_flags : op request
//   rd_sel_a / rd_data_a, rd_sel_b / rd_data_b        : combinational read ports
//   op_done, ovf, err                                 : status back to the master
`timescale 1ns/1ps
interface reg_bank_ops_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    localparam int SELW = $clog2(NUM_REGS);

    logic             op_valid;
    logic [2:0]       op;
    logic [SELW-1:0]  dst_sel;
    logic [SELW-1:0]  src_sel;
    logic [WIDTH-1:0] wdata;
    logic             clr_flags;
    logic [SELW-1:0]  rd_sel_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [SELW-1:0]  rd_sel_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             op_done;
    logic             ovf;
    logic             err;

    modport master (
        output op_valid, op, dst_sel, src_sel, wdata, clr_flags,
        output rd_sel_a, rd_sel_b,
        input  rd_data_a, rd_data_b, op_done, ovf, err
    );

    modport slave (
        input  op_valid, op, dst_sel, src_sel, wdata, clr_flags,
        input  rd_sel_a, rd_sel_b,
        output rd_data_a, rd_data_b, op_done, ovf, err
    );
endinterface

// File: rtl/reg_bank_ops.sv
// reg_bank_ops
//   Bank of NUM_REGS general registers of WIDTH bits with single-cycle ops
//   (NOP, LOAD, CLR, INC, DEC, MOVE, SWAP, CLRALL) and two combinational
//   read ports. All state changes on the falling edge of clk.
//
//   Ports:
//     clk    : system clock, state updates on negedge
//     rst_n  : asynchronous active-low reset, clears registers and status
//     bus    : reg_bank_ops_if.slave (op request, read ports, op_done/ovf/err)
//
//   Build option:
//     INC_SAT_EN : when defined, INC at all-ones and DEC at zero saturate
//                  instead of wrapping; ovf is set either way.
`timescale 1ns/1ps
module reg_bank_ops #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input logic           clk,
    input logic           rst_n,
    reg_bank_ops_if.slave bus
);
    localparam int SELW = $clog2(NUM_REGS);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_LOAD   = 3'b001,
        OP_CLR    = 3'b010,
        OP_INC    = 3'b011,
        OP_DEC    = 3'b100,
        OP_MOVE   = 3'b101,
        OP_SWAP   = 3'b110,
        OP_CLRALL = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             op_done_q;
    logic             ovf_q;
    logic             err_q;
    logic             ovf_set;
    logic             err_set;
    logic             dst_ok;
    logic             src_ok;
    logic [WIDTH-1:0] dst_val;
    logic [WIDTH-1:0] src_val;

    // When NUM_REGS is not a power of two the select fields can name
    // registers that do not exist.
    function automatic logic in_range(input logic [SELW-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    assign dst_ok  = in_range(bus.dst_sel);
    assign src_ok  = in_range(bus.src_sel);
    assign dst_val = dst_ok ? regs_q[bus.dst_sel] : '0;
    assign src_val = src_ok ? regs_q[bus.src_sel] : '0;

    always_comb begin
        regs_d  = regs_q;
        ovf_set = 1'b0;
        err_set = 1'b0;
        if (bus.op_valid) begin
            case (op_e'(bus.op))
                OP_NOP: begin
                end
                OP_LOAD: begin
                    if (dst_ok) regs_d[bus.dst_sel] = bus.wdata;
                    else        err_set = 1'b1;
                end
                OP_CLR: begin
                    if (dst_ok) regs_d[bus.dst_sel] = '0;
                    else        err_set = 1'b1;
                end
                OP_INC: begin
                    if (!dst_ok) begin
                        err_set = 1'b1;
                    end else if (&dst_val) begin
                        ovf_set = 1'b1;
`ifdef INC_SAT_EN
                        regs_d[bus.dst_sel] = dst_val;
`else
                        regs_d[bus.dst_sel] = '0;
`endif
                    end else begin
                        regs_d[bus.dst_sel] = dst_val + ONE;
                    end
                end
                OP_DEC: begin
                    if (!dst_ok) begin
                        err_set = 1'b1;
                    end else if (dst_val == '0) begin
                        ovf_set = 1'b1;
`ifdef INC_SAT_EN
                        regs_d[bus.dst_sel] = '0;
`else
                        regs_d[bus.dst_sel] = '1;
`endif
                    end else begin
                        regs_d[bus.dst_sel] = dst_val - ONE;
                    end
                end
                OP_MOVE: begin
                    if (dst_ok && src_ok) regs_d[bus.dst_sel] = src_val;
                    else                  err_set = 1'b1;
                end
                OP_SWAP: begin
                    // Both writes use the pre-edge values; dst==src writes
                    // the same value back, so it is naturally a no-op.
                    if (dst_ok && src_ok) begin
                        regs_d[bus.dst_sel] = src_val;
                        regs_d[bus.src_sel] = dst_val;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                OP_CLRALL: begin
                    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            op_done_q <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            op_done_q <= bus.op_valid;
            // A flag raised this cycle survives a simultaneous clear.
            ovf_q     <= (ovf_q & ~bus.clr_flags) | ovf_set;
            err_q     <= (err_q & ~bus.clr_flags) | err_set;
        end
    end

    assign bus.rd_data_a = in_range(bus.rd_sel_a) ? regs_q[bus.rd_sel_a] : '0;
    assign bus.rd_data_b = in_range(bus.rd_sel_b) ? regs_q[bus.rd_sel_b] : '0;
    assign bus.op_done   = op_done_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule
